// File: rtl/decode_stage_pkg.sv
// Shared types for the decode stage: opcodes, ALU functions, the decoded
// instruction record and its reset value.
`default_nettype none

package decode_stage_pkg;

  typedef logic [31:0] word_t;

  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam word_t INSTR_ECALL  = 32'h0000_0073;
  localparam word_t INSTR_EBREAK = 32'h0010_0073;
  localparam word_t INSTR_MRET   = 32'h3020_0073;

  typedef enum logic [4:0] {
    alu_nop, alu_add, alu_sub, alu_slt, alu_sltu, alu_and, alu_or, alu_xor,
    alu_sll, alu_srl, alu_sra,
    alu_mul, alu_mulh, alu_mulhsu, alu_mulhu, alu_div, alu_divu, alu_rem, alu_remu
  } alu_fn_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    alu_fn_t     alu_fn;
    logic        use_pc;
    logic        use_imm;
    logic        has_rd;
    logic        is_load;
    logic        is_store;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        is_jump;
    logic        is_branch;
    logic        is_mret;
    logic        is_illegal;
  } instr_t;

  // Decode of addi x0, x0, 0 (0x00000013).
  localparam instr_t NOP_DECODE = '{
    rd: 5'd0, rs1: 5'd0, rs2: 5'd0, imm: 32'd0, alu_fn: alu_add,
    use_pc: 1'b0, use_imm: 1'b1, has_rd: 1'b0, is_load: 1'b0, is_store: 1'b0,
    mem_size: 2'd0, mem_unsigned: 1'b0, is_jump: 1'b0, is_branch: 1'b0,
    is_mret: 1'b0, is_illegal: 1'b0
  };

  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;

  function automatic alu_fn_t alu_base_fn(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? alu_sub : alu_add;
      3'd1:    return alu_sll;
      3'd2:    return alu_slt;
      3'd3:    return alu_sltu;
      3'd4:    return alu_xor;
      3'd5:    return alt ? alu_sra : alu_srl;
      3'd6:    return alu_or;
      default: return alu_and;
    endcase
  endfunction

  function automatic alu_fn_t alu_muldiv_fn(input logic [2:0] f3);
    case (f3)
      3'd0:    return alu_mul;
      3'd1:    return alu_mulh;
      3'd2:    return alu_mulhsu;
      3'd3:    return alu_mulhu;
      3'd4:    return alu_div;
      3'd5:    return alu_divu;
      3'd6:    return alu_rem;
      default: return alu_remu;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_stage_decoder.sv
// decoder_core: combinational RV32I(+M) decoder with optional illegal-encoding detection.
`default_nettype none

module decoder_core
  import decode_stage_pkg::*;
#(
  parameter bit ENABLE_M      = 1'b0,
  parameter bit CHECK_ILLEGAL = 1'b1
) (
  input  logic [31:0] data_i,
  output instr_t      instr_o
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        illegal;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  instr_t      d;

  assign opcode = data_i[6:0];
  assign f3     = data_i[14:12];
  assign f7     = data_i[31:25];
  assign imm_i  = {{20{data_i[31]}}, data_i[31:20]};
  assign imm_s  = {{20{data_i[31]}}, data_i[31:25], data_i[11:7]};
  assign imm_b  = {{19{data_i[31]}}, data_i[31], data_i[7], data_i[30:25], data_i[11:8], 1'b0};
  assign imm_u  = {data_i[31:12], 12'd0};
  assign imm_j  = {{11{data_i[31]}}, data_i[31], data_i[19:12], data_i[20], data_i[30:21], 1'b0};

  always_comb begin
    d         = NOP_DECODE;
    d.use_imm = 1'b0;
    d.alu_fn  = alu_nop;
    d.rd      = data_i[11:7];
    d.rs1     = data_i[19:15];
    d.rs2     = data_i[24:20];
    d.imm     = imm_i;
    illegal   = 1'b0;
    case (opcode)
      OPCODE_LUI: begin
        d.imm = imm_u; d.use_imm = 1'b1; d.has_rd = 1'b1;
      end
      OPCODE_AUIPC: begin
        d.imm = imm_u; d.alu_fn = alu_add; d.use_pc = 1'b1; d.use_imm = 1'b1; d.has_rd = 1'b1;
      end
      OPCODE_JAL: begin
        d.imm = imm_j; d.alu_fn = alu_add; d.use_pc = 1'b1; d.use_imm = 1'b1;
        d.has_rd = 1'b1; d.is_jump = 1'b1;
      end
      OPCODE_JALR: begin
        d.alu_fn = alu_add; d.use_imm = 1'b1; d.has_rd = 1'b1; d.is_jump = 1'b1;
        illegal = (f3 != 3'd0);
      end
      OPCODE_BRANCH: begin
        d.imm = imm_b; d.alu_fn = alu_add; d.use_pc = 1'b1; d.use_imm = 1'b1; d.is_branch = 1'b1;
        illegal = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OPCODE_LOAD: begin
        d.alu_fn = alu_add; d.use_imm = 1'b1; d.has_rd = 1'b1; d.is_load = 1'b1;
        d.mem_size = f3[1:0]; d.mem_unsigned = f3[2];
        illegal = (f3 == 3'd3) || (f3 >= 3'd6);
      end
      OPCODE_STORE: begin
        d.imm = imm_s; d.alu_fn = alu_add; d.use_imm = 1'b1; d.is_store = 1'b1;
        d.mem_size = f3[1:0];
        illegal = (f3 >= 3'd3);
      end
      OPCODE_OP_IMM: begin
        d.alu_fn = alu_base_fn(f3, (f3 == 3'd5) && f7[5]); d.use_imm = 1'b1; d.has_rd = 1'b1;
        illegal = ((f3 == 3'd1) && (f7 != FUNCT7_BASE)) ||
                  ((f3 == 3'd5) && (f7 != FUNCT7_BASE) && (f7 != FUNCT7_ALT));
      end
      OPCODE_OP: begin
        d.has_rd = 1'b1;
        d.alu_fn = (ENABLE_M && f7 == FUNCT7_MULDIV) ? alu_muldiv_fn(f3) : alu_base_fn(f3, f7[5]);
        illegal = !((f7 == FUNCT7_BASE) ||
                    ((f7 == FUNCT7_ALT) && ((f3 == 3'd0) || (f3 == 3'd5))) ||
                    ((f7 == FUNCT7_MULDIV) && ENABLE_M));
      end
      OPCODE_SYSTEM: begin
        d.is_mret = (data_i == INSTR_MRET);
        d.has_rd  = (f3 != 3'd0);
        illegal = (f3 == 3'd4) ||
                  ((f3 == 3'd0) && (data_i != INSTR_MRET) &&
                   (data_i != INSTR_ECALL) && (data_i != INSTR_EBREAK));
      end
      OPCODE_MISC_MEM: ;
      default: illegal = 1'b1;
    endcase
    if (data_i[1:0] != 2'b11) illegal = 1'b1;
    if (!CHECK_ILLEGAL) illegal = 1'b0;
    // Writes to x0 are architecturally discarded, so they never claim a destination.
    d.has_rd     = d.has_rd && (d.rd != 5'd0);
    d.is_illegal = illegal;
    if (illegal) begin
      d.has_rd = 1'b0; d.is_load = 1'b0; d.is_store = 1'b0;
      d.is_jump = 1'b0; d.is_branch = 1'b0; d.is_mret = 1'b0;
    end
    instr_o = d;
  end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// decode_stage: registered decode pipeline stage with valid/ready handshakes,
// optional 2-entry skid buffer and flush.
`default_nettype none

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter bit ENABLE_M      = 1'b0,
  parameter bit CHECK_ILLEGAL = 1'b1,
  parameter bit SKID          = 1'b1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  input  logic [31:0] in_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output instr_t      out_instr_o,
  output logic [31:0] out_pc_o
);

  instr_t dec;

  decoder_core #(
    .ENABLE_M      (ENABLE_M),
    .CHECK_ILLEGAL (CHECK_ILLEGAL)
  ) u_decoder (
    .data_i  (in_data_i),
    .instr_o (dec)
  );

  if (SKID) begin : g_skid
    skid_state_t state_q;
    instr_t      out_instr_q, skid_instr_q;
    logic [31:0] out_pc_q, skid_pc_q;
    logic        out_valid_q, in_ready_q;
    logic        in_xfer, out_xfer;

    assign in_xfer  = in_valid_i && in_ready_q;
    assign out_xfer = out_valid_q && out_ready_i;

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        state_q      <= EMPTY;
        out_valid_q  <= 1'b0;
        in_ready_q   <= 1'b1;
        out_instr_q  <= NOP_DECODE;
        out_pc_q     <= '0;
        skid_instr_q <= NOP_DECODE;
        skid_pc_q    <= '0;
      end else if (flush_i) begin
        state_q     <= EMPTY;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b1;
      end else begin
        case (state_q)
          EMPTY: if (in_xfer) begin
            out_instr_q <= dec;
            out_pc_q    <= in_pc_i;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
          ONE: if (in_xfer && !out_xfer) begin
            skid_instr_q <= dec;
            skid_pc_q    <= in_pc_i;
            in_ready_q   <= 1'b0;
            state_q      <= TWO;
          end else if (in_xfer) begin
            out_instr_q <= dec;
            out_pc_q    <= in_pc_i;
          end else if (out_xfer) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
          TWO: if (out_xfer) begin
            out_instr_q <= skid_instr_q;
            out_pc_q    <= skid_pc_q;
            in_ready_q  <= 1'b1;
            state_q     <= ONE;
          end
          default: begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= EMPTY;
          end
        endcase
      end
    end

    // Registered ready, only gated by reset so nothing is taken on a reset cycle.
    assign in_ready_o  = in_ready_q && !reset_i;
    assign out_valid_o = out_valid_q;
    assign out_instr_o = out_instr_q;
    assign out_pc_o    = out_pc_q;
  end else begin : g_single
    instr_t      out_instr_q;
    logic [31:0] out_pc_q;
    logic        out_valid_q;
    logic        in_ready;

    assign in_ready = !reset_i && (!out_valid_q || out_ready_i);

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        out_valid_q <= 1'b0;
        out_instr_q <= NOP_DECODE;
        out_pc_q    <= '0;
      end else if (flush_i) begin
        out_valid_q <= 1'b0;
      end else if (in_valid_i && in_ready) begin
        out_instr_q <= dec;
        out_pc_q    <= in_pc_i;
        out_valid_q <= 1'b1;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid_q;
    assign out_instr_o = out_instr_q;
    assign out_pc_o    = out_pc_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: decode, M extension, backpressure, flush, reset, SKID=0.
`default_nettype none

module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready, in_valid_c, out_ready_c;
  logic [31:0] in_data, in_pc;
  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
  logic [31:0] a_out_pc, b_out_pc, c_out_pc;
  instr_t      a_instr, b_instr, c_instr;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.ENABLE_M(1'b1), .CHECK_ILLEGAL(1'b1), .SKID(1'b1)) u_dut_a (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
    .in_data_i(in_data), .in_pc_i(in_pc), .out_valid_o(a_out_valid), .out_ready_i(out_ready),
    .out_instr_o(a_instr), .out_pc_o(a_out_pc));

  decode_stage #(.ENABLE_M(1'b0), .CHECK_ILLEGAL(1'b1), .SKID(1'b1)) u_dut_b (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(b_in_ready),
    .in_data_i(in_data), .in_pc_i(in_pc), .out_valid_o(b_out_valid), .out_ready_i(out_ready),
    .out_instr_o(b_instr), .out_pc_o(b_out_pc));

  decode_stage #(.ENABLE_M(1'b1), .CHECK_ILLEGAL(1'b1), .SKID(1'b0)) u_dut_c (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .in_valid_i(in_valid_c), .in_ready_o(c_in_ready),
    .in_data_i(in_data), .in_pc_i(in_pc), .out_valid_o(c_out_valid), .out_ready_i(out_ready_c),
    .out_instr_o(c_instr), .out_pc_o(c_out_pc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] data, input logic [31:0] pc);
    in_valid = 1'b1; in_data = data; in_pc = pc;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_valid_c = 1'b0; out_ready_c = 1'b0; in_data = 32'h0; in_pc = 32'h0;

    // Reset state
    tick();
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd0);
    chk("rst_out_pc", a_out_pc, 32'h0);
    chk("rst_alu_fn", 32'(a_instr.alu_fn), 32'(alu_add));
    chk("rst_has_rd", 32'(a_instr.has_rd), 32'd0);
    chk("rst_use_imm", 32'(a_instr.use_imm), 32'd1);
    chk("rst_illegal", 32'(a_instr.is_illegal), 32'd0);
    chk("rst_imm", a_instr.imm, 32'h0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(a_in_ready), 32'd1);

    // Decode and latency
    out_ready = 1'b1;
    feed(32'h0050_0093, 32'h100);
    tick();
    chk("addi_valid", 32'(a_out_valid), 32'd1);
    chk("addi_rd", 32'(a_instr.rd), 32'd1);
    chk("addi_rs1", 32'(a_instr.rs1), 32'd0);
    chk("addi_imm", a_instr.imm, 32'd5);
    chk("addi_fn", 32'(a_instr.alu_fn), 32'(alu_add));
    chk("addi_use_imm", 32'(a_instr.use_imm), 32'd1);
    chk("addi_has_rd", 32'(a_instr.has_rd), 32'd1);
    chk("addi_pc", a_out_pc, 32'h100);
    feed(32'h4020_8133, 32'h104);
    tick();
    chk("sub_fn", 32'(a_instr.alu_fn), 32'(alu_sub));
    chk("sub_rd", 32'(a_instr.rd), 32'd2);
    chk("sub_use_imm", 32'(a_instr.use_imm), 32'd0);
    chk("sub_pc", a_out_pc, 32'h104);
    feed(32'h3020_0073, 32'h108);
    tick();
    chk("mret_is_mret", 32'(a_instr.is_mret), 32'd1);
    chk("mret_has_rd", 32'(a_instr.has_rd), 32'd0);

    // M extension
    feed(32'h0220_81B3, 32'h10C);
    tick();
    chk("mul_fn", 32'(a_instr.alu_fn), 32'(alu_mul));
    chk("mul_rd", 32'(a_instr.rd), 32'd3);
    chk("mul_illegal", 32'(a_instr.is_illegal), 32'd0);
    chk("nom_valid", 32'(b_out_valid), 32'd1);
    chk("nom_illegal", 32'(b_instr.is_illegal), 32'd1);
    chk("nom_has_rd", 32'(b_instr.has_rd), 32'd0);
    chk("nom_pc", b_out_pc, 32'h10C);
    feed(32'hFFFF_FFFF, 32'h110);
    tick();
    chk("ones_illegal", 32'(a_instr.is_illegal), 32'd1);
    chk("ones_has_rd", 32'(a_instr.has_rd), 32'd0);
    feed(32'h0000_2063, 32'h114);
    tick();
    chk("bf3_illegal", 32'(a_instr.is_illegal), 32'd1);
    chk("bf3_is_branch", 32'(a_instr.is_branch), 32'd0);
    feed(32'h0000_A103, 32'h118);
    tick();
    chk("lw_is_load", 32'(a_instr.is_load), 32'd1);
    chk("lw_illegal", 32'(a_instr.is_illegal), 32'd0);
    chk("lw_rd", 32'(a_instr.rd), 32'd2);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(a_out_valid), 32'd0);

    // Backpressure: A, B held; C stalls
    out_ready = 1'b0;
    feed(32'h0010_0093, 32'h200);
    tick();
    chk("bp_a_valid", 32'(a_out_valid), 32'd1);
    chk("bp_a_ready", 32'(a_in_ready), 32'd1);
    feed(32'h0020_0113, 32'h204);
    tick();
    chk("bp_b_ready", 32'(a_in_ready), 32'd0);
    chk("bp_b_nom_ready", 32'(b_in_ready), 32'd0);
    chk("bp_b_head", a_instr.imm, 32'd1);
    feed(32'h0030_0193, 32'h208);
    tick();
    chk("bp_c_ready", 32'(a_in_ready), 32'd0);
    chk("bp_c_head", a_instr.imm, 32'd1);
    chk("bp_c_head_pc", a_out_pc, 32'h200);
    out_ready = 1'b1;
    tick();
    chk("drain_b_imm", a_instr.imm, 32'd2);
    chk("drain_b_pc", a_out_pc, 32'h204);
    chk("drain_b_ready", 32'(a_in_ready), 32'd1);
    tick();
    chk("drain_c_imm", a_instr.imm, 32'd3);
    chk("drain_c_pc", a_out_pc, 32'h208);
    chk("drain_c_valid", 32'(a_out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("drain_empty", 32'(a_out_valid), 32'd0);

    // Flush in TWO with in_valid
    out_ready = 1'b0;
    feed(32'h0040_0213, 32'h300);
    tick();
    feed(32'h0050_0293, 32'h304);
    tick();
    flush = 1'b1;
    feed(32'h0060_0313, 32'h308);
    tick();
    chk("flush2_valid", 32'(a_out_valid), 32'd0);
    chk("flush2_ready", 32'(a_in_ready), 32'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("flush2_after", 32'(a_out_valid), 32'd0);

    // Flush in ONE drops a simultaneous accepted word
    out_ready = 1'b0;
    feed(32'h0070_0393, 32'h30C);
    tick();
    flush = 1'b1;
    feed(32'h0080_0413, 32'h310);
    tick();
    chk("flush1_valid", 32'(a_out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("flush1_after", 32'(a_out_valid), 32'd0);

    // Reset mid-stream in TWO
    feed(32'h0070_0393, 32'h400);
    tick();
    feed(32'h0080_0413, 32'h404);
    tick();
    reset = 1'b1;
    feed(32'h0090_0493, 32'h408);
    tick();
    chk("mrst_valid", 32'(a_out_valid), 32'd0);
    chk("mrst_imm", a_instr.imm, 32'd0);
    chk("mrst_fn", 32'(a_instr.alu_fn), 32'(alu_add));
    chk("mrst_pc", a_out_pc, 32'h0);
    reset = 1'b0; out_ready = 1'b1;
    feed(32'h00A0_0513, 32'h500);
    #1;
    chk("mrst_ready", 32'(a_in_ready), 32'd1);
    tick();
    chk("mrst_first_valid", 32'(a_out_valid), 32'd1);
    chk("mrst_first_imm", a_instr.imm, 32'd10);
    chk("mrst_first_pc", a_out_pc, 32'h500);
    in_valid = 1'b0;
    tick();

    // SKID=0 instance
    in_valid_c = 1'b1; out_ready_c = 1'b1;
    in_data = 32'h00B0_0593; in_pc = 32'h600;
    #1;
    chk("ns_ready_empty", 32'(c_in_ready), 32'd1);
    tick();
    chk("ns_first_imm", c_instr.imm, 32'd11);
    chk("ns_first_valid", 32'(c_out_valid), 32'd1);
    in_data = 32'h00C0_0613; in_pc = 32'h604; out_ready_c = 1'b0;
    #1;
    chk("ns_ready_stall", 32'(c_in_ready), 32'd0);
    tick();
    chk("ns_hold_imm", c_instr.imm, 32'd11);
    out_ready_c = 1'b1;
    #1;
    chk("ns_ready_go", 32'(c_in_ready), 32'd1);
    tick();
    chk("ns_second_imm", c_instr.imm, 32'd12);
    chk("ns_second_pc", c_out_pc, 32'h604);
    in_data = 32'h00D0_0693; in_pc = 32'h608;
    tick();
    chk("ns_third_imm", c_instr.imm, 32'd13);
    in_valid_c = 1'b0; out_ready_c = 1'b0;
    #1;
    chk("ns_ready_full", 32'(c_in_ready), 32'd0);
    tick();
    chk("ns_held_valid", 32'(c_out_valid), 32'd1);
    out_ready_c = 1'b1;
    #1;
    chk("ns_ready_drain", 32'(c_in_ready), 32'd1);
    tick();
    chk("ns_empty", 32'(c_out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
